// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch-stage PC register and instruction-bus requester. It holds the
// architectural fetch PC and issues one bus request per PC. The request
// address stays stable until the memory returns data. The fetched
// instruction is presented to the IF/ID boundary with a valid/ready
// handshake. The block consumes pc_nxt from the next-PC mux and supplies
// out_pcplus4 back to it.
//
// Ports:
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous active-high reset
//   pc_nxt         in  64   next PC; sampled on redirect or HOLD handshake
//   redirect       in   1   flush fetch state and load pc_nxt
//   ireq_valid     out  1   instruction-bus request valid
//   ireq_addr      out 64   instruction-bus request address
//   iresp_data_ok  in   1   response pulse for the outstanding request
//   iresp_data     in  32   instruction word, valid with iresp_data_ok
//   out_valid      out  1   instruction valid toward decode
//   out_ready      in   1   decode accepts this cycle
//   out_pc         out 64   PC of presented instruction
//   out_instr      out 32   presented instruction word
//   out_pcplus4    out 64   out_pc + 4 (mod 2^64)
//   out_exc        out  1   instruction-address-misaligned flag
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   When defined, a misaligned fetch address is not requested on the bus.
//   The unit goes straight to HOLD, presenting a NOP with out_exc set.
//   When undefined, out_exc is tied 0 and every address is requested as-is.
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] pc_nxt,
   input  logic        redirect,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic [63:0] out_pcplus4,
   output logic        out_exc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic [31:0] instr_q, instr_d;

   // A "launch" loads a new request address. Every path that starts a new
   // request goes through it, so the optional misalignment check lives in
   // one place.
   logic        launch;
   logic [63:0] launch_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic exc_q, exc_d;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      instr_d     = instr_q;
      launch      = 1'b0;
      launch_addr = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      exc_d       = exc_q;
`endif

      unique case (state_q)
         IDLE: begin
            launch = 1'b1;
            if (redirect) begin
               pc_d        = pc_nxt;
               launch_addr = pc_nxt;
            end
         end

         FETCH: begin
            if (iresp_data_ok) begin
               if (redirect) begin
                  pc_d        = pc_nxt;
                  launch      = 1'b1;
                  launch_addr = pc_nxt;
               end else begin
                  instr_d = iresp_data;
                  state_d = HOLD;
               end
            end else if (redirect) begin
               // The old request stays on the bus until it completes.
               pc_d    = pc_nxt;
               state_d = DROP;
            end
         end

         DROP: begin
            if (redirect) begin
               pc_d = pc_nxt;
            end
            if (iresp_data_ok) begin
               // Stale data is discarded. Refetch from the newest PC,
               // including a redirect that arrives in this same cycle.
               launch      = 1'b1;
               launch_addr = redirect ? pc_nxt : pc_q;
            end
         end

         HOLD: begin
            if (redirect || out_ready) begin
               pc_d        = pc_nxt;
               launch      = 1'b1;
               launch_addr = pc_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
               exc_d       = 1'b0;
`endif
            end
         end

         default: state_d = IDLE;
      endcase

      if (launch) begin
         req_addr_d = launch_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
         if (launch_addr[1:0] != 2'b00) begin
            state_d = HOLD;
            instr_d = 32'h0000_0013;
            exc_d   = 1'b1;
         end else begin
            state_d = FETCH;
         end
`else
         state_d = FETCH;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         instr_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_q <= 1'b0;
      end else begin
         exc_q <= exc_d;
      end
   end

   assign out_exc = exc_q;
`else
   assign out_exc = 1'b0;
`endif

   assign ireq_valid  = (state_q == FETCH) || (state_q == DROP);
   assign ireq_addr   = req_addr_q;
   assign out_valid   = (state_q == HOLD);
   assign out_pc      = req_addr_q;
   assign out_instr   = instr_q;
   assign out_pcplus4 = req_addr_q + 64'd4;

endmodule
